// File: rtl/fifo_rptr_empty_if.sv
// Read-side bundle of the async FIFO pointer/empty controller.
// Carries ralmost_empty only when FIFO_ALMOST_EMPTY_EN is defined.
interface fifo_rptr_empty_if #(
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  rd_en;
   logic [ADDR_WIDTH:0]   rq2_wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  rempty;
   logic                  rd_fire;
   logic [ADDR_WIDTH:0]   rlevel;
`ifdef FIFO_ALMOST_EMPTY_EN
   logic                  ralmost_empty;
`endif

   // Master is the consumer/synchronizer side, slave is the pointer controller.
   modport master (
      output rd_en,
      output rq2_wptr,
      input  rptr,
      input  raddr,
      input  rempty,
      input  rd_fire,
      input  rlevel
`ifdef FIFO_ALMOST_EMPTY_EN
      ,
      input  ralmost_empty
`endif
   );

   modport slave (
      input  rd_en,
      input  rq2_wptr,
      output rptr,
      output raddr,
      output rempty,
      output rd_fire,
      output rlevel
`ifdef FIFO_ALMOST_EMPTY_EN
      ,
      output ralmost_empty
`endif
   );
endinterface

// File: rtl/fifo_rptr_empty.sv
// Async FIFO read pointer, Gray pointer export, registered empty flag and occupancy estimate.
// Optional registered almost-empty flag enabled by defining FIFO_ALMOST_EMPTY_EN.
module fifo_rptr_empty #(
   parameter int unsigned ADDR_WIDTH = 3
`ifdef FIFO_ALMOST_EMPTY_EN
   ,
   parameter int unsigned AE_THRESH  = 2
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_rptr_empty_if.slave  bus
);
   localparam int unsigned PW = ADDR_WIDTH + 1;

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] rlevel_q, rlevel_d;
   logic [PW-1:0] wbin;
   logic          rempty_q, rempty_d;
   logic          rd_fire;

   always_comb begin
      rd_fire  = bus.rd_en & ~rempty_q;
      rbin_d   = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
      rptr_d   = rbin_d ^ (rbin_d >> 1);
      rempty_d = (rptr_d == bus.rq2_wptr);

      // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
      wbin         = '0;
      wbin[PW-1]   = bus.rq2_wptr[PW-1];
      for (int i = int'(PW) - 2; i >= 0; i--) begin
         wbin[i] = wbin[i+1] ^ bus.rq2_wptr[i];
      end
      rlevel_d = wbin - rbin_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbin_q   <= '0;
         rptr_q   <= '0;
         rempty_q <= 1'b1;
         rlevel_q <= '0;
      end else begin
         rbin_q   <= rbin_d;
         rptr_q   <= rptr_d;
         rempty_q <= rempty_d;
         rlevel_q <= rlevel_d;
      end
   end

   assign bus.rd_fire = rd_fire;
   assign bus.raddr   = rbin_q[ADDR_WIDTH-1:0];
   assign bus.rptr    = rptr_q;
   assign bus.rempty  = rempty_q;
   assign bus.rlevel  = rlevel_q;

`ifdef FIFO_ALMOST_EMPTY_EN
   localparam logic [PW-1:0] AeThresh = AE_THRESH[PW-1:0];

   logic ralmost_empty_q, ralmost_empty_d;

   always_comb begin
      ralmost_empty_d = (rlevel_d <= AeThresh);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ralmost_empty_q <= 1'b1;
      end else begin
         ralmost_empty_q <= ralmost_empty_d;
      end
   end

   assign bus.ralmost_empty = ralmost_empty_q;
`endif
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Scoreboard bench for fifo_rptr_empty (ADDR_WIDTH=3); per-cycle expectations are queued
// at stimulus time and popped after the edge that produces them.
module tb_fifo_rptr_empty;
   localparam int unsigned AW = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_rptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef FIFO_ALMOST_EMPTY_EN
   fifo_rptr_empty #(.ADDR_WIDTH(AW), .AE_THRESH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`else
   fifo_rptr_empty #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   typedef struct {
      logic [3:0] rptr;
      logic       empty;
      logic [3:0] level;
      logic       ae;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Model of registered read-side state, in plain binary counts.
   logic [3:0] m_rbin;
   logic       m_empty;

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_rbin  = 4'd0;
      m_empty = 1'b1;
      sb.delete();
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic rd, input logic [3:0] wb);
      logic       fire;
      logic [3:0] nb;
      logic [3:0] prev;
      exp_t       e;
      exp_t       got;
      bus.rd_en    = rd;
      bus.rq2_wptr = to_gray(wb);
      #1;
      fire = rd & ~m_empty;
      total++;
      if (bus.rd_fire !== fire) begin
         bad++;
         $display("FAIL rd_fire got=%b exp=%b t=%0t", bus.rd_fire, fire, $time);
      end
      total++;
      if (bus.raddr !== m_rbin[2:0]) begin
         bad++;
         $display("FAIL raddr got=%0d exp=%0d t=%0t", bus.raddr, m_rbin[2:0], $time);
      end
      nb      = m_rbin + {3'b000, fire};
      e.rptr  = to_gray(nb);
      e.empty = (nb == wb);
      e.level = wb - nb;
      e.ae    = (e.level <= 4'd2);
      sb.push_back(e);
      prev = bus.rptr;
      @(posedge clk);
      #1;
      got = sb.pop_front();
      total++;
      if (bus.rptr !== got.rptr) begin
         bad++;
         $display("FAIL rptr got=%b exp=%b t=%0t", bus.rptr, got.rptr, $time);
      end
      total++;
      if (bus.rempty !== got.empty) begin
         bad++;
         $display("FAIL rempty got=%b exp=%b t=%0t", bus.rempty, got.empty, $time);
      end
      total++;
      if (bus.rlevel !== got.level) begin
         bad++;
         $display("FAIL rlevel got=%0d exp=%0d t=%0t", bus.rlevel, got.level, $time);
      end
      total++;
      if ($countones(prev ^ bus.rptr) !== (fire ? 1 : 0)) begin
         bad++;
         $display("FAIL rptr_onebit prev=%b now=%b fire=%b", prev, bus.rptr, fire);
      end
`ifdef FIFO_ALMOST_EMPTY_EN
      total++;
      if (bus.ralmost_empty !== got.ae) begin
         bad++;
         $display("FAIL ralmost_empty got=%b exp=%b t=%0t", bus.ralmost_empty, got.ae, $time);
      end
`endif
      m_rbin  = nb;
      m_empty = got.empty;
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      total++;
      if (bus.rptr !== 4'b0000 || bus.rempty !== 1'b1 || bus.rlevel !== 4'd0 ||
          bus.raddr !== 3'd0 || bus.rd_fire !== 1'b0) begin
         bad++;
         $display("FAIL %s got rptr=%b rempty=%b rlevel=%0d raddr=%0d rd_fire=%b exp 0000/1/0/0/0",
                  tag, bus.rptr, bus.rempty, bus.rlevel, bus.raddr, bus.rd_fire);
      end
`ifdef FIFO_ALMOST_EMPTY_EN
      total++;
      if (bus.ralmost_empty !== 1'b1) begin
         bad++;
         $display("FAIL %s_ae got=%b exp=1", tag, bus.ralmost_empty);
      end
`endif
   endtask

   task automatic test_reset();
      bus.rd_en    = 1'b1;
      bus.rq2_wptr = 4'b0110;
      rst_n        = 1'b0;
      model_reset();
      #1;
      check_reset_state("reset_initial");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_reset_state("reset_hold");
      end
      @(negedge clk);
   endtask

   task automatic test_drain();
      rst_n = 1'b1;
      step(1'b0, 4'd4);
      total++;
      if (bus.rempty !== 1'b0 || bus.rlevel !== 4'd4) begin
         bad++;
         $display("FAIL drain_start rempty=%b rlevel=%0d exp 0/4", bus.rempty, bus.rlevel);
      end
      for (int i = 0; i < 5; i++) step(1'b1, 4'd4);
      total++;
      if (bus.rptr !== 4'b0110 || bus.rempty !== 1'b1) begin
         bad++;
         $display("FAIL drain_end rptr=%b rempty=%b exp 0110/1", bus.rptr, bus.rempty);
      end
   endtask

   task automatic test_wrap();
      for (int i = 1; i <= 12; i++) step(1'b1, 4'(4 + i));
      step(1'b1, 4'd0);
      total++;
      if (bus.rptr !== 4'b0000 || bus.rempty !== 1'b1 || bus.raddr !== 3'd0) begin
         bad++;
         $display("FAIL wrap_end rptr=%b rempty=%b raddr=%0d exp 0000/1/0",
                  bus.rptr, bus.rempty, bus.raddr);
      end
   endtask

   task automatic test_full_depth();
      step(1'b0, 4'd8);
      total++;
      if (bus.rlevel !== 4'd8 || bus.rempty !== 1'b0) begin
         bad++;
         $display("FAIL full_level rlevel=%0d rempty=%b exp 8/0", bus.rlevel, bus.rempty);
      end
      for (int i = 0; i < 8; i++) step(1'b1, 4'd8);
      total++;
      if (bus.rlevel !== 4'd0 || bus.rempty !== 1'b1) begin
         bad++;
         $display("FAIL full_drain rlevel=%0d rempty=%b exp 0/1", bus.rlevel, bus.rempty);
      end
   endtask

   task automatic test_async_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 4'd6);
      step(1'b1, 4'd6);
      step(1'b1, 4'd6);
      total++;
      if (bus.rptr !== 4'b0011) begin
         bad++;
         $display("FAIL async_pre rptr=%b exp=0011", bus.rptr);
      end
      bus.rd_en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state("async_reset_midcycle");
      @(posedge clk);
      #1;
      check_reset_state("async_reset_edge");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      // Writes become visible in the same cycles as reads.
      step(1'b0, 4'd3);
`ifdef FIFO_ALMOST_EMPTY_EN
      total++;
      if (bus.rlevel !== 4'd3 || bus.ralmost_empty !== 1'b0) begin
         bad++;
         $display("FAIL ae_level3 rlevel=%0d ae=%b exp 3/0", bus.rlevel, bus.ralmost_empty);
      end
`endif
      step(1'b1, 4'd3);
`ifdef FIFO_ALMOST_EMPTY_EN
      total++;
      if (bus.rlevel !== 4'd2 || bus.ralmost_empty !== 1'b1) begin
         bad++;
         $display("FAIL ae_level2 rlevel=%0d ae=%b exp 2/1", bus.rlevel, bus.ralmost_empty);
      end
`endif
      for (int i = 0; i < 10; i++) step(1'b1, 4'(4 + i));
      for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 4'(13 + i / 3));
   endtask

   initial begin
      bus.rd_en    = 1'b0;
      bus.rq2_wptr = 4'b0000;
      rst_n        = 1'b1;
      @(negedge clk);
      test_reset();
      test_drain();
      test_wrap();
      test_full_depth();
      test_async_reset();
      test_back_to_back();
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
